// File: rtl/rr_arb_fsm_if.sv
// Purpose: request/grant bundle between N requesters and the round-robin arbiter.
// Latency: none (wires only).
// Backpressure: none; req is a held level, done is a single-cycle strobe.
interface rr_arb_fsm_if #(
    parameter int N = 4
) ();
    logic [N-1:0]         req;
    logic [N-1:0]         done;
    logic [N-1:0]         grant;
    logic                 grant_valid;
    logic [$clog2(N)-1:0] grant_id;
    logic                 timeout;

    // Requester side drives req/done and observes the grant.
    modport master (
        output req,
        output done,
        input  grant,
        input  grant_valid,
        input  grant_id,
        input  timeout
    );

    // Arbiter side observes req/done and drives the grant.
    modport slave (
        input  req,
        input  done,
        output grant,
        output grant_valid,
        output grant_id,
        output timeout
    );
endinterface

// File: rtl/rr_arb_fsm.sv
// Purpose: round-robin arbiter with grant hold, release on done/req drop/hold budget.
// Latency: 1 cycle req->grant, 1 cycle release->grant low, 1 idle bubble between owners.
// Backpressure: requesters wait by holding req; a grant lasts at most MAX_HOLD cycles.
module rr_arb_fsm #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arb_fsm_if.slave   arb
);
    localparam int IW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [IW-1:0]   grant_id_q, grant_id_d;
    logic            timeout_q, timeout_d;

    logic            pick_found;
    logic [IW-1:0]   pick_id;
    int              scan_idx;

    // Scan requests starting at the rotating pointer and wrap modulo N.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        scan_idx   = 0;
        for (int i = 0; i < N; i++) begin
            scan_idx = (int'(ptr_q) + i) % N;
            if (!pick_found && arb.req[scan_idx]) begin
                pick_found = 1'b1;
                pick_id    = IW'(scan_idx);
            end
        end
    end

    // Next-state logic: take a new owner in IDLE, decide hold/release in GRANT.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        timeout_d  = 1'b0;

        case (state_q)
            IDLE: begin
                grant_d    = '0;
                grant_id_d = '0;
                if (pick_found) begin
                    grant_d    = N'(1) << pick_id;
                    grant_id_d = pick_id;
                    hold_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                // done outranks a req drop, which outranks budget expiry,
                // so a voluntary release never reports a timeout.
                if (arb.done[grant_id_q] || !arb.req[grant_id_q]
                    || (hold_cnt_q == HW'(MAX_HOLD - 1))) begin
                    timeout_d  = !arb.done[grant_id_q] && arb.req[grant_id_q];
                    state_d    = IDLE;
                    grant_d    = '0;
                    grant_id_d = '0;
                    hold_cnt_d = '0;
                    ptr_d      = (grant_id_q == IW'(N - 1)) ? '0 : grant_id_q + IW'(1);
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                grant_d    = '0;
                grant_id_d = '0;
                hold_cnt_d = '0;
            end
        endcase
    end

    // State register; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            grant_q    <= '0;
            grant_id_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            timeout_q  <= timeout_d;
        end
    end

    assign arb.grant       = grant_q;
    assign arb.grant_valid = |grant_q;
    assign arb.grant_id    = grant_id_q;
    assign arb.timeout     = timeout_q;
endmodule

// File: tb/tb_rr_arb_fsm.sv
// Purpose: directed self-checking bench for rr_arb_fsm (N=4, MAX_HOLD=16).
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled there too.
// Backpressure: not applicable; stimulus is a fixed cycle-by-cycle script.
module tb_rr_arb_fsm;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    rr_arb_fsm_if #(.N(4)) arb_if ();

    rr_arb_fsm #(.N(4), .MAX_HOLD(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (arb_if.slave)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        arb_if.req  = 4'b0000;
        arb_if.done = 4'b0000;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        arb_if.req  = 4'b1111;
        arb_if.done = 4'b0000;
        #3;
        tests++;
        if (arb_if.grant !== 4'b0000 || arb_if.grant_valid !== 1'b0 ||
            arb_if.grant_id !== 2'd0 || arb_if.timeout !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: grant=%b valid=%b id=%0d to=%b, need 0000/0/0/0",
                     arb_if.grant, arb_if.grant_valid, arb_if.grant_id, arb_if.timeout);
        end
        tick();
        tests++;
        if (arb_if.grant !== 4'b0000) begin
            fails++;
            $display("FAIL reset_held: grant=%b need 0000", arb_if.grant);
        end
        rst_n = 1'b1;
        tick();
        tests++;
        if (arb_if.grant !== 4'b0001 || arb_if.grant_valid !== 1'b1 || arb_if.grant_id !== 2'd0) begin
            fails++;
            $display("FAIL reset_first_grant: grant=%b valid=%b id=%0d, need 0001/1/0",
                     arb_if.grant, arb_if.grant_valid, arb_if.grant_id);
        end
    endtask

    task automatic test_single_done();
        do_reset();
        arb_if.req = 4'b0100;
        for (int c = 1; c <= 3; c++) begin
            tick();
            tests++;
            if (arb_if.grant !== 4'b0100 || arb_if.grant_id !== 2'd2) begin
                fails++;
                $display("FAIL single_hold c%0d: grant=%b id=%0d, need 0100/2",
                         c, arb_if.grant, arb_if.grant_id);
            end
        end
        arb_if.done = 4'b0100;
        tick();
        arb_if.done = 4'b0000;
        tests++;
        if (arb_if.grant !== 4'b0000 || arb_if.grant_valid !== 1'b0 || arb_if.timeout !== 1'b0) begin
            fails++;
            $display("FAIL single_release: grant=%b valid=%b to=%b, need 0000/0/0",
                     arb_if.grant, arb_if.grant_valid, arb_if.timeout);
        end
        tick();
        tests++;
        if (arb_if.grant !== 4'b0100) begin
            fails++;
            $display("FAIL single_regrant: grant=%b need 0100", arb_if.grant);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_seq [9];
        exp_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                    4'b0000, 4'b1000, 4'b0000, 4'b0001};
        do_reset();
        arb_if.req = 4'b1111;
        for (int i = 0; i < 9; i++) begin
            tick();
            tests++;
            if (arb_if.grant !== exp_seq[i] || arb_if.grant_valid !== (exp_seq[i] != 4'b0000)) begin
                fails++;
                $display("FAIL rotation step%0d: grant=%b valid=%b, need %b",
                         i, arb_if.grant, arb_if.grant_valid, exp_seq[i]);
            end
            // Owner releases on its first grant cycle.
            arb_if.done = exp_seq[i];
        end
        arb_if.done = 4'b0000;
    endtask

    task automatic test_hold_budget();
        int bad;
        do_reset();
        arb_if.req = 4'b0010;
        bad = 0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (arb_if.grant !== 4'b0010 || arb_if.timeout !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL hold_16_cycles: %0d bad cycles, need 0", bad);
        end
        tick();
        tests++;
        if (arb_if.grant !== 4'b0000 || arb_if.timeout !== 1'b1) begin
            fails++;
            $display("FAIL hold_timeout: grant=%b to=%b, need 0000/1", arb_if.grant, arb_if.timeout);
        end
        tick();
        tests++;
        if (arb_if.grant !== 4'b0010 || arb_if.timeout !== 1'b0) begin
            fails++;
            $display("FAIL hold_regrant: grant=%b to=%b, need 0010/0", arb_if.grant, arb_if.timeout);
        end
        // This is grant cycle 1; walk to cycle 16 and strobe done there.
        for (int c = 2; c <= 16; c++) tick();
        tests++;
        if (arb_if.grant !== 4'b0010) begin
            fails++;
            $display("FAIL hold_cycle16: grant=%b need 0010", arb_if.grant);
        end
        arb_if.done = 4'b0010;
        tick();
        arb_if.done = 4'b0000;
        tests++;
        if (arb_if.grant !== 4'b0000 || arb_if.timeout !== 1'b0) begin
            fails++;
            $display("FAIL hold_done_wins: grant=%b to=%b, need 0000/0", arb_if.grant, arb_if.timeout);
        end
    endtask

    task automatic test_withdraw();
        do_reset();
        arb_if.req = 4'b1000;
        tick();
        tests++;
        if (arb_if.grant !== 4'b1000 || arb_if.grant_id !== 2'd3) begin
            fails++;
            $display("FAIL withdraw_owner: grant=%b id=%0d, need 1000/3", arb_if.grant, arb_if.grant_id);
        end
        arb_if.done = 4'b0001;
        tick();
        arb_if.done = 4'b0000;
        arb_if.req  = 4'b1001;
        tests++;
        if (arb_if.grant !== 4'b1000) begin
            fails++;
            $display("FAIL withdraw_foreign_done: grant=%b need 1000", arb_if.grant);
        end
        tick();
        tests++;
        if (arb_if.grant !== 4'b1000) begin
            fails++;
            $display("FAIL withdraw_foreign_req: grant=%b need 1000", arb_if.grant);
        end
        arb_if.req = 4'b0001;
        tick();
        tests++;
        if (arb_if.grant !== 4'b0000 || arb_if.timeout !== 1'b0) begin
            fails++;
            $display("FAIL withdraw_release: grant=%b to=%b, need 0000/0", arb_if.grant, arb_if.timeout);
        end
        arb_if.req = 4'b1001;
        tick();
        tests++;
        if (arb_if.grant !== 4'b0001 || arb_if.grant_id !== 2'd0) begin
            fails++;
            $display("FAIL withdraw_wrap: grant=%b id=%0d, need 0001/0", arb_if.grant, arb_if.grant_id);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        arb_if.req = 4'b0100;
        tick();
        tick();
        tests++;
        if (arb_if.grant !== 4'b0100) begin
            fails++;
            $display("FAIL async_pre: grant=%b need 0100", arb_if.grant);
        end
        rst_n = 1'b0;
        #2;
        tests++;
        if (arb_if.grant !== 4'b0000 || arb_if.grant_valid !== 1'b0 || arb_if.grant_id !== 2'd0) begin
            fails++;
            $display("FAIL async_clear: grant=%b valid=%b id=%0d, need 0000/0/0",
                     arb_if.grant, arb_if.grant_valid, arb_if.grant_id);
        end
        arb_if.req = 4'b1100;
        tick();
        rst_n = 1'b1;
        tick();
        tests++;
        if (arb_if.grant !== 4'b0100 || arb_if.grant_id !== 2'd2) begin
            fails++;
            $display("FAIL async_after: grant=%b id=%0d, need 0100/2", arb_if.grant, arb_if.grant_id);
        end
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        rst_n       = 1'b0;
        arb_if.req  = 4'b0000;
        arb_if.done = 4'b0000;
        test_reset();
        test_single_done();
        test_rotation();
        test_hold_budget();
        test_withdraw();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rr_arb_fsm.md
# rr_arb_fsm

Round-robin arbiter with a grant-hold state machine, sharing one downstream resource among `N` requesters. It is the multi-requester, fairness-enforcing successor to the team's fixed-priority two-way arbiter. A grant is held until the owner signals completion, withdraws its request, or exhausts a hold budget. The block sits between requester `req`/`done` lines and the resource's select/enable logic.

## Interface
Parameters:
- `N`, default 4: number of requesters; legal range N ≥ 2.
- `MAX_HOLD`, default 16: maximum consecutive cycles a grant may be held; legal range MAX_HOLD ≥ 1.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req`  in  N  request per requester; level, held high while the resource is wanted.
- `done`  in  N  release strobe per requester; only the bit of the current owner is observed.
- `grant`  out  N  one-hot grant, registered; all-zero when no owner.
- `grant_valid`  out  1  high exactly when `grant` is non-zero.
- `grant_id`  out  $clog2(N)  binary index of the owner; 0 when `grant_valid` is low.
- `timeout`  out  1  one-cycle pulse: the previous grant was revoked by the hold budget.

## Operation
- Internal state:
  - `state` ∈ {IDLE, GRANT}.
  - Rotating pointer `ptr` (width $clog2(N)).
  - Hold counter `hold_cnt` (width $clog2(MAX_HOLD+1)).
- Reset (`rst_n` low, takes effect immediately without a clock edge):
  - `state` = IDLE.
  - `grant`, `grant_valid`, `grant_id`, `timeout`, `hold_cnt`, `ptr` all 0.
- IDLE:
  - `grant` is 0.
  - If any `req` bit is set, select the first set bit scanning `ptr`, `ptr+1`, …, wrapping modulo N.
  - At the edge: load the one-hot `grant` and `grant_id`, set `hold_cnt` = 0, and go to GRANT.
  - With no requests, stay in IDLE.
- GRANT (owner = `grant_id`), release conditions evaluated at each edge in this priority:
  1. `done[grant_id]` = 1 → release, `timeout` stays 0.
  2. `req[grant_id]` = 0 → release, `timeout` stays 0.
  3. `hold_cnt` == MAX_HOLD−1 → release and `timeout` = 1 for the next cycle.
  4. Otherwise `hold_cnt` increments and the grant is held.
- On any release:
  - Go to IDLE; `grant`, `grant_valid` and `grant_id` become 0.
  - `ptr` = (`grant_id`+1) mod N.
  - `hold_cnt` = 0.
- Inputs ignored while in GRANT:
  - `done` bits of non-owners.
  - `req` changes of non-owners.
- `done` is ignored in IDLE.
- `timeout` is cleared at every edge where it is not being set.
- Invariants:
  - `grant` is always one-hot or zero.
  - `grant_valid` equals OR(`grant`).
  - `grant_id` matches the set bit of `grant`.

## Timing
- Request to grant latency: 1 cycle. A `req` sampled at edge k drives `grant` valid after edge k.
- Release latency: 1 cycle. A `done` or `req` drop sampled at edge k drives `grant` to 0 after edge k.
- Each release is followed by at least one IDLE cycle with `grant` = 0 (a mandatory bubble). Back-to-back ownership therefore has a 1-cycle gap.
- Maximum grant duration: MAX_HOLD cycles. `timeout` is high in the first IDLE cycle after a budget revoke.
- Simultaneous `done` and budget expiry: `done` wins, `timeout` stays 0.
- Worst-case wait for a continuously requesting requester: (N−1)·(MAX_HOLD+1) cycles.
- MAX_HOLD = 1: every grant lasts exactly one cycle; `timeout` pulses unless `done` or a `req` drop coincides.
- `rst_n` asserted mid-grant clears all outputs asynchronously. The first grant after reset goes to the lowest-index requesting bit.
- `rst_n` deassertion is assumed synchronous to `clk` upstream. The block samples inputs at the first edge with `rst_n` high.

## Test plan
- Reset under load: `rst_n`=0 with `req`=4'b1111 → `grant`=0, `grant_valid`=0, `grant_id`=0, `timeout`=0. Release reset → `grant`=4'b0001 one edge later.
- Single owner with `done`: `req`=4'b0100 held; pulse `done[2]` on the 3rd grant cycle → `grant`=4'b0100 for 3 cycles, then 0 with `timeout`=0; one cycle later re-grant 4'b0100.
- Rotation fairness: `req`=4'b1111 held; each owner pulses `done` on its 1st grant cycle → `grant` sequence 0001,0,0010,0,0100,0,1000,0,0001.
- Hold budget (MAX_HOLD=16): `req`=4'b0010 held, no `done` → `grant`=4'b0010 for exactly 16 cycles, then `timeout`=1 for 1 cycle with `grant`=0, then 4'b0010 again. Also drive `done[1]` on cycle 16 → `timeout` stays 0.
- Withdrawal and ignored strobes: owner 3, pulse `done[0]` → no effect; drop `req[3]` → `grant`=0 next edge, `timeout`=0. With `req`=4'b1001 pending, the next grant is 4'b0001 (pointer wrapped to 0).
- Asynchronous reset mid-grant: assert `rst_n`=0 between edges during grant 4'b0100 → `grant`=0 before the next edge. After release with `req`=4'b1100 → grant 4'b0100 (pointer back at 0).
